// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU result stage: op encodings, flag indices and FSM states.
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_ADC = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_SBB = 2'b11;

    localparam int unsigned FLG_C = 0;
    localparam int unsigned FLG_Z = 1;
    localparam int unsigned FLG_N = 2;
    localparam int unsigned FLG_V = 3;

    typedef logic [3:0] alu_flags_t;

    typedef enum logic {
        StIdle,
        StChain
    } stage_state_t;

    function automatic logic is_sub(input logic [1:0] op);
        return (op == ALU_SUB) || (op == ALU_SBB);
    endfunction

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational per-byte flag derivation: N, V, byte-zero and carry/borrow conversion.
module alu_flag_calc
    import alu_pkg::*;
(
    input  logic [7:0] sum,
    input  logic       cout,
    input  logic [1:0] S,
    input  logic       a_msb,
    input  logic       b_msb,
    output alu_flags_t flags
);

    always_comb begin
        flags        = '0;
        // Subtracts store a borrow, i.e. the inverse of the adder carry-out.
        flags[FLG_C] = is_sub(S) ? ~cout : cout;
        flags[FLG_Z] = (sum == 8'h00);
        flags[FLG_N] = sum[7];
        flags[FLG_V] = (a_msb == b_msb) && (sum[7] != a_msb);
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU back end: result register, carry feedback, multi-byte chain tracking and chain flags.
// Define ALU_ZERO_CHAIN_EN to make flag_z cover the whole chain instead of the last byte only.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 4,
    localparam int unsigned W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_last,
    input  logic [1:0]   S,
    input  logic [7:0]   sum,
    input  logic         cout,
    input  logic         a_msb,
    input  logic         b_msb,
    output logic         cin_q,
    output logic [7:0]   res_data,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] byte_idx,
    output logic         flags_valid,
    output logic         flag_c,
    output logic         flag_z,
    output logic         flag_n,
    output logic         flag_v,
    output logic         chain_err
);

    stage_state_t state;
    logic [W-1:0] cnt;
    alu_flags_t   flags;
    alu_flags_t   byte_flags;
    alu_flags_t   chain_flags;
    logic [W-1:0] cur_idx;
    logic         at_max;
    logic         is_last;
    logic         forced;
    logic         accept;
`ifdef ALU_ZERO_CHAIN_EN
    logic         z_acc;
`endif

    alu_flag_calc u_flag_calc (
        .sum   (sum),
        .cout  (cout),
        .S     (S),
        .a_msb (a_msb),
        .b_msb (b_msb),
        .flags (byte_flags)
    );

    assign in_ready = !res_valid || res_ready;
    assign accept   = in_valid && in_ready;

    // cnt holds the index of the most recently accepted byte, so it doubles as byte_idx.
    assign cur_idx  = (state == StChain) ? cnt + W'(1) : '0;
    assign at_max   = (cur_idx == W'(MAX_BYTES - 1));
    assign is_last  = in_last || at_max;
    assign forced   = at_max && !in_last;

    always_comb begin
        chain_flags = byte_flags;
`ifdef ALU_ZERO_CHAIN_EN
        chain_flags[FLG_Z] = z_acc && byte_flags[FLG_Z];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            cnt         <= '0;
            res_data    <= 8'h00;
            res_valid   <= 1'b0;
            flags_valid <= 1'b0;
            flags       <= '0;
            chain_err   <= 1'b0;
            cin_q       <= 1'b0;
`ifdef ALU_ZERO_CHAIN_EN
            z_acc       <= 1'b1;
`endif
        end else if (accept) begin
            res_data    <= sum;
            res_valid   <= 1'b1;
            cin_q       <= byte_flags[FLG_C];
            cnt         <= cur_idx;
            flags_valid <= is_last;
            chain_err   <= forced;
            if (is_last) begin
                state <= StIdle;
                flags <= chain_flags;
`ifdef ALU_ZERO_CHAIN_EN
                z_acc <= 1'b1;
`endif
            end else begin
                state <= StChain;
`ifdef ALU_ZERO_CHAIN_EN
                z_acc <= z_acc && byte_flags[FLG_Z];
`endif
            end
        end else if (res_ready) begin
            res_valid   <= 1'b0;
            flags_valid <= 1'b0;
            chain_err   <= 1'b0;
        end
    end

    assign byte_idx = cnt;
    assign flag_c   = flags[FLG_C];
    assign flag_z   = flags[FLG_Z];
    assign flag_n   = flags[FLG_N];
    assign flag_v   = flags[FLG_V];

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage with hand-computed expectations.
module tb_alu_result_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_last;
    logic [1:0] S;
    logic [7:0] sum;
    logic       cout;
    logic       a_msb;
    logic       b_msb;
    logic       cin_q;
    logic [7:0] res_data;
    logic       res_valid;
    logic       res_ready;
    logic [1:0] byte_idx;
    logic       flags_valid;
    logic       flag_c;
    logic       flag_z;
    logic       flag_n;
    logic       flag_v;
    logic       chain_err;

    int n_tests = 0;
    int n_fail  = 0;

    alu_result_stage #(.MAX_BYTES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_last     (in_last),
        .S           (S),
        .sum         (sum),
        .cout        (cout),
        .a_msb       (a_msb),
        .b_msb       (b_msb),
        .cin_q       (cin_q),
        .res_data    (res_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .byte_idx    (byte_idx),
        .flags_valid (flags_valid),
        .flag_c      (flag_c),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .flag_v      (flag_v),
        .chain_err   (chain_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte for a single clock edge; returns 1 time unit after the edge.
    task automatic send(input logic [1:0] op, input logic [7:0] s, input logic co,
                        input logic am, input logic bm, input logic last);
        in_valid = 1'b1;
        S        = op;
        sum      = s;
        cout     = co;
        a_msb    = am;
        b_msb    = bm;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        S         = 2'b00;
        sum       = 8'h00;
        cout      = 1'b0;
        a_msb     = 1'b0;
        b_msb     = 1'b0;
        res_ready = 1'b1;

        #3;
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 8'h00);
        check("rst_flags_valid", flags_valid, 0);
        check("rst_cin_q", cin_q, 0);
        check("rst_byte_idx", byte_idx, 0);
        check("rst_flags", {flag_c, flag_z, flag_n, flag_v, chain_err}, 0);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: ADD 0x7F + 0x01
        send(2'b00, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t1_res_data", res_data, 8'h80);
        check("t1_res_valid", res_valid, 1);
        check("t1_flags_valid", flags_valid, 1);
        check("t1_byte_idx", byte_idx, 0);
        check("t1_cnzv", {flag_c, flag_z, flag_n, flag_v}, 4'b0011);
        check("t1_cin_q", cin_q, 0);
        check("t1_chain_err", chain_err, 0);

        // 2: SUB 0x00 - 0x01, borrow expected
        send(2'b10, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
        check("t2_cin_q", cin_q, 1);
        check("t2_cnzv", {flag_c, flag_z, flag_n, flag_v}, 4'b1010);

        // 3a: 16-bit SUB 0x0100 - 0x0100
        send(2'b10, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        check("t3a_b0_flags_valid", flags_valid, 0);
        check("t3a_b0_byte_idx", byte_idx, 0);
        check("t3a_b0_cin_q", cin_q, 0);
        send(2'b11, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        check("t3a_b1_flags_valid", flags_valid, 1);
        check("t3a_b1_byte_idx", byte_idx, 1);
        check("t3a_b1_cin_q", cin_q, 0);
        check("t3a_cnzv", {flag_c, flag_z, flag_n, flag_v}, 4'b0100);

        // 3b: 0x0001 + 0x0000, low byte nonzero
        send(2'b00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        send(2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t3b_flags_valid", flags_valid, 1);
`ifdef ALU_ZERO_CHAIN_EN
        check("t3b_flag_z", flag_z, 0);
`else
        check("t3b_flag_z", flag_z, 1);
`endif
        check("t3b_flag_c", flag_c, 0);

        // 4: backpressure
        @(posedge clk);
        #1;
        check("t4_drained", res_valid, 0);
        res_ready = 1'b0;
        send(2'b00, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_first_valid", res_valid, 1);
        in_valid = 1'b1;
        sum      = 8'h22;
        for (int i = 0; i < 3; i++) begin
            check("t4_stall_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
            check("t4_stall_res_data", res_data, 8'h11);
            check("t4_stall_res_valid", res_valid, 1);
            check("t4_stall_flags_valid", flags_valid, 1);
        end
        res_ready = 1'b1;
        #1;
        check("t4_release_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t4_next_res_data", res_data, 8'h22);
        check("t4_next_res_valid", res_valid, 1);
        @(posedge clk);
        #1;
        check("t4_consumed_res_valid", res_valid, 0);
        check("t4_consumed_flags_valid", flags_valid, 0);

        // 5: forced chain end at MAX_BYTES
        for (int i = 0; i < 5; i++) begin
            send(2'b00, 8'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0);
            check("t5_byte_idx", byte_idx, (i == 4) ? 8'd0 : 8'(i));
            check("t5_flags_valid", flags_valid, (i == 3) ? 8'd1 : 8'd0);
            check("t5_chain_err", chain_err, (i == 3) ? 8'd1 : 8'd0);
        end
        send(2'b01, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_close_byte_idx", byte_idx, 1);
        check("t5_close_chain_err", chain_err, 0);

        // 6: reset in the middle of a 3-byte chain
        send(2'b10, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        send(2'b11, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t6_pre_cin_q", cin_q, 1);
        check("t6_pre_byte_idx", byte_idx, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_res_valid", res_valid, 0);
        check("t6_rst_res_data", res_data, 8'h00);
        check("t6_rst_cin_q", cin_q, 0);
        check("t6_rst_byte_idx", byte_idx, 0);
        check("t6_rst_flags", {flags_valid, flag_c, flag_z, flag_n, flag_v, chain_err}, 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(2'b00, 8'h05, 1'b1, 1'b0, 1'b0, 1'b1);
        check("t6_post_byte_idx", byte_idx, 0);
        check("t6_post_cin_q", cin_q, 1);
        check("t6_post_flags_valid", flags_valid, 1);
        check("t6_post_flag_c", flag_c, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Back end of the 8-bit ALU datapath. Sits after the operand/carry front-end and its adder.
- Each cycle it can accept one adder result byte (sum, carry-out) tagged with the 2-bit op select.
- It registers the result byte, converts carry-out into the stored carry/borrow flag and feeds that flag back as the front-end `cin`.
- It tracks multi-byte chains and reports the C/Z/N/V flags at the end of each chain.

Parameters:
- MAX_BYTES, 4, maximum bytes per chain; the byte counter is $clog2(MAX_BYTES) bits wide (min 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  adder result byte present.
- in_ready  out  1  stage can accept a byte.
- in_last  in  1  byte is the final (most significant) byte of the chain.
- S  in  2  op select applied to the front-end for this byte: 00 ADD, 01 ADC, 10 SUB, 11 SBB.
- sum  in  8  adder sum.
- cout  in  1  adder carry-out.
- a_msb  in  1  bit 7 of the adder operand A (post-mux).
- b_msb  in  1  bit 7 of the adder operand B (post-mux, i.e. after complement).
- cin_q  out  1  stored carry/borrow flag, wired to the front-end `cin`.
- res_data  out  8  registered result byte.
- res_valid  out  1  res_data valid.
- res_ready  in  1  consumer accepts res_data.
- byte_idx  out  W  index of the byte held in res_data within its chain.
- flags_valid  out  1  asserted together with res_valid on the last byte of a chain.
- flag_c, flag_z, flag_n, flag_v  out  1 each  chain flags; meaningful only while flags_valid=1.
- chain_err  out  1  asserted with flags_valid when the chain was force-terminated.

Behaviour:
- Reset (async, rst_n=0):
  - res_data=0, res_valid=0, flags_valid=0, all flags=0, chain_err=0, byte_idx=0, cin_q=0.
  - Internal state=IDLE, counter=0, z_acc=1.
  - A reset mid-chain discards the chain and any held output.
- Handshake:
  - in_ready = !res_valid || res_ready (single output register, full-throughput pass-through).
  - A byte is accepted when in_valid && in_ready.
  - res_valid rises the cycle after acceptance. Latency is 1 cycle.
  - res_data and all flag/idx outputs stay stable while res_valid && !res_ready.
  - res_valid falls after a consumed transfer unless a new byte is accepted in the same cycle.
- Carry conversion, on each accepted byte:
  - cin_q <= S[1] ? ~cout : cout.
  - Add stores carry. Subtract stores borrow (1 = borrow), which matches the front-end using ~cin for SBB.
  - cin_q is held otherwise, including while idle between chains.
- States:
  - IDLE: no chain open. An accepted byte becomes byte 0. If in_last=1 (or MAX_BYTES=1), go to IDLE; else go to CHAIN.
  - CHAIN: an accepted byte increments the counter. If in_last=1, go to IDLE.
  - Forced end: a byte with counter==MAX_BYTES-1 and in_last=0 is treated as last, sets chain_err=1, and goes to IDLE.
  - The S value is not checked against chain position; the controller is responsible for issuing ADC/SBB after byte 0.
- Flags, computed on the last byte and registered with res_data:
  - N = sum[7].
  - V = (a_msb==b_msb) && (sum[7]!=a_msb).
  - C = new cin_q value.
  - Z: see Optional Feature.
- z_acc:
  - Cleared to 1 at every chain end.
  - On every accepted non-last byte: z_acc <= z_acc && (sum==0).
- byte_idx = counter value of the accepted byte.
- Simultaneous res_ready and a new in_valid in the same cycle are legal; the output register reloads without a bubble.

Optional Feature:
- Macro: ALU_ZERO_CHAIN_EN.
- Defined: flag_z = z_acc && (sum==0), i.e. the whole multi-byte result is zero.
- Undefined: flag_z = (sum==0) of the last byte only; z_acc logic is removed.

Decomposition:
- Shared package alu_pkg holds:
  - Op constants ALU_ADD=2'b00, ALU_ADC=2'b01, ALU_SUB=2'b10, ALU_SBB=2'b11.
  - Flag index constants FLG_C, FLG_Z, FLG_N, FLG_V.
  - A 4-bit flags typedef.
- One natural sub-module, alu_flag_calc: combinational N/V/Z-byte/carry conversion from sum, cout, S, a_msb and b_msb. The top level keeps the FSM, counter and registers.

Test Plan:
1. Single ADD 0x7F+0x01: sum=0x80, cout=0, in_last=1 -> res_data=0x80, N=1, V=1, C=0, Z=0, cin_q=0, flags_valid=1, byte_idx=0.
2. SUB 0x00-0x01: sum=0xFF, cout=0, a_msb=0, b_msb=1 -> cin_q=1 (borrow), C=1, N=1, V=0, Z=0.
3. 16-bit SUB 0x0100-0x0100: byte0 SUB sum=0x00, cout=1; byte1 SBB sum=0x00, cout=1, last -> cin_q=0, Z=1, C=0, byte_idx=1. Also 0x0001+0x0000 (byte0 sum=0x01, byte1 sum=0x00) -> Z=0 with ALU_ZERO_CHAIN_EN, Z=1 without.
4. Backpressure: res_ready=0 with res_valid=1, in_valid=1 -> in_ready=0 and outputs stable for 3 cycles; res_ready=1 with in_valid=1 in the same cycle -> next byte appears the following cycle with no bubble.
5. MAX_BYTES=4, five bytes with in_last=0 -> byte_idx=3 carries flags_valid=1 and chain_err=1; the fifth byte starts a new chain at byte_idx=0.
6. Assert rst_n=0 after byte1 of a 3-byte chain -> all outputs immediately 0. After release, the next byte reports byte_idx=0 and cin_q starts from 0.
